// File: rtl/compound_arbiter_pkg.sv
// Arbiter-local types: FSM sections and requester identity.
package compound_arbiter_types;

  typedef enum logic [1:0] {
    arb_idle,
    arb_send_one,
    arb_send_two
  } ArbSections;

  typedef enum logic {
    req_a = 1'b0,
    req_b = 1'b1
  } Requester;

  function automatic Requester other_req(input Requester r);
    return (r == req_a) ? req_b : req_a;
  endfunction

endpackage

// File: rtl/top_level_types.sv
// Shared system-level payload type carried on blocking ports.
package top_level_types;

  localparam int COORD_W = 8;

  typedef enum logic {
    read  = 1'b0,
    write = 1'b1
  } ModeType;

  typedef struct packed {
    ModeType            mode;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } CompoundType;

  localparam CompoundType COMPOUND_RESET = '{mode: read, x: '0, y: '0};

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/compound_arbiter.sv
// Two-requester round-robin arbiter onto one blocking CompoundType port.
// State table:  arb_idle | both inputs open, output empty
//               arb_send_one | one item on arb_out, inputs closed
//               arb_send_two | item on arb_out plus one waiting in slot1
module compound_arbiter
  import top_level_types::*;
  import compound_arbiter_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  CompoundType       a_in,
  input  logic              a_in_sync,
  output logic              a_in_notify,
  input  CompoundType       b_in,
  input  logic              b_in_sync,
  output logic              b_in_notify,
  output CompoundType       arb_out,
  output Requester          arb_out_src,
  input  logic              arb_out_sync,
  output logic              arb_out_notify,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);

  ArbSections  section_q, section_d;
  Requester    prio_q, prio_d;
  CompoundType out_q, out_d;
  Requester    src_q, src_d;
  CompoundType slot1_q, slot1_d;
  Requester    slot1_src_q, slot1_src_d;
  logic        a_notify_q, a_notify_d;
  logic        b_notify_q, b_notify_d;
  logic        out_notify_q, out_notify_d;

  logic a_take, b_take, deliver;
  logic inc_a, inc_b;

  assign a_take  = a_notify_q && a_in_sync;
  assign b_take  = b_notify_q && b_in_sync;
  assign deliver = out_notify_q && arb_out_sync;

  always_comb begin
    section_d    = section_q;
    prio_d       = prio_q;
    out_d        = out_q;
    src_d        = src_q;
    slot1_d      = slot1_q;
    slot1_src_d  = slot1_src_q;
    a_notify_d   = a_notify_q;
    b_notify_d   = b_notify_q;
    out_notify_d = out_notify_q;

    case (section_q)
      arb_idle: begin
        if (a_take && b_take) begin
          // Priority holder goes out first, the other waits in slot1.
          if (prio_q == req_a) begin
            out_d       = a_in;
            src_d       = req_a;
            slot1_d     = b_in;
            slot1_src_d = req_b;
          end else begin
            out_d       = b_in;
            src_d       = req_b;
            slot1_d     = a_in;
            slot1_src_d = req_a;
          end
          prio_d    = other_req(prio_q);
          section_d = arb_send_two;
        end else if (a_take) begin
          out_d     = a_in;
          src_d     = req_a;
          prio_d    = req_b;
          section_d = arb_send_one;
        end else if (b_take) begin
          out_d     = b_in;
          src_d     = req_b;
          prio_d    = req_a;
          section_d = arb_send_one;
        end
        if (a_take || b_take) begin
          a_notify_d   = 1'b0;
          b_notify_d   = 1'b0;
          out_notify_d = 1'b1;
        end
      end
      arb_send_two: begin
        if (deliver) begin
          out_d     = slot1_q;
          src_d     = slot1_src_q;
          section_d = arb_send_one;
        end
      end
      arb_send_one: begin
        if (deliver) begin
          out_notify_d = 1'b0;
          a_notify_d   = 1'b1;
          b_notify_d   = 1'b1;
          section_d    = arb_idle;
        end
      end
      default: begin
        section_d    = arb_idle;
        out_notify_d = 1'b0;
        a_notify_d   = 1'b1;
        b_notify_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      section_q    <= arb_idle;
      prio_q       <= req_a;
      out_q        <= COMPOUND_RESET;
      src_q        <= req_a;
      slot1_q      <= COMPOUND_RESET;
      slot1_src_q  <= req_a;
      a_notify_q   <= 1'b1;
      b_notify_q   <= 1'b1;
      out_notify_q <= 1'b0;
    end else begin
      section_q    <= section_d;
      prio_q       <= prio_d;
      out_q        <= out_d;
      src_q        <= src_d;
      slot1_q      <= slot1_d;
      slot1_src_q  <= slot1_src_d;
      a_notify_q   <= a_notify_d;
      b_notify_q   <= b_notify_d;
      out_notify_q <= out_notify_d;
    end
  end

  // Credit the source of whatever item leaves on this edge.
  assign inc_a = deliver && (src_q == req_a);
  assign inc_b = deliver && (src_q == req_b);

  sat_counter #(.W(CNT_W)) u_a_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_a),
    .count (a_count)
  );

  sat_counter #(.W(CNT_W)) u_b_count (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc_b),
    .count (b_count)
  );

  assign arb_out        = out_q;
  assign arb_out_src    = src_q;
  assign arb_out_notify = out_notify_q;
  assign a_in_notify    = a_notify_q;
  assign b_in_notify    = b_notify_q;

endmodule

// File: tb/tb_compound_arbiter.sv
// Scoreboard bench for compound_arbiter; a CNT_W=2 twin shares the stimulus.
module tb_compound_arbiter;
  import top_level_types::*;
  import compound_arbiter_types::*;

  typedef struct packed {
    CompoundType d;
    Requester    s;
  } exp_t;

  logic        clk;
  logic        rst;
  CompoundType a_in, b_in;
  logic        a_in_sync, b_in_sync, arb_out_sync;
  logic        a_in_notify, b_in_notify, arb_out_notify;
  CompoundType arb_out;
  Requester    arb_out_src;
  logic [15:0] a_count, b_count;

  logic        s_a_notify, s_b_notify, s_out_notify;
  CompoundType s_arb_out;
  Requester    s_arb_out_src;
  logic [1:0]  s_a_count, s_b_count;

  exp_t     sbq[$];
  exp_t     mon_e;
  int       n_checks = 0;
  int       n_errors = 0;
  int       m_a = 0;
  int       m_b = 0;
  Requester m_prio = req_a;

  compound_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_in_sync(a_in_sync), .a_in_notify(a_in_notify),
    .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(b_in_notify),
    .arb_out(arb_out), .arb_out_src(arb_out_src),
    .arb_out_sync(arb_out_sync), .arb_out_notify(arb_out_notify),
    .a_count(a_count), .b_count(b_count)
  );

  compound_arbiter #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst),
    .a_in(a_in), .a_in_sync(a_in_sync), .a_in_notify(s_a_notify),
    .b_in(b_in), .b_in_sync(b_in_sync), .b_in_notify(s_b_notify),
    .arb_out(s_arb_out), .arb_out_src(s_arb_out_src),
    .arb_out_sync(arb_out_sync), .arb_out_notify(s_out_notify),
    .a_count(s_a_count), .b_count(s_b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic CompoundType mk(input ModeType m, input logic [7:0] x, input logic [7:0] y);
    CompoundType c;
    c.mode = m;
    c.x    = x;
    c.y    = y;
    return c;
  endfunction

  function automatic logic [31:0] sat(input int n, input int maxv);
    return (n > maxv) ? 32'(maxv) : 32'(n);
  endfunction

  function automatic void push(input CompoundType d, input Requester s);
    exp_t e;
    e.d = d;
    e.s = s;
    sbq.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && arb_out_notify && arb_out_sync) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected", 32'(arb_out), 32'hFFFF_FFFF);
      end else begin
        mon_e = sbq.pop_front();
        chk("sb_data", 32'(arb_out), 32'(mon_e.d));
        chk("sb_src", 32'(arb_out_src), 32'(mon_e.s));
        if (mon_e.s == req_a) m_a++;
        else                  m_b++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    a_in_sync = 1'b0;
    b_in_sync = 1'b0;
    sbq.delete();
    m_prio = req_a;
    m_a    = 0;
    m_b    = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Called at posedge+1 with the DUT idle; presents requests for one edge.
  task automatic send(input bit da, input CompoundType pa, input bit db, input CompoundType pb);
    a_in      = pa;
    b_in      = pb;
    a_in_sync = da;
    b_in_sync = db;
    if (da && db) begin
      if (m_prio == req_a) begin
        push(pa, req_a);
        push(pb, req_b);
      end else begin
        push(pb, req_b);
        push(pa, req_a);
      end
      m_prio = other_req(m_prio);
    end else if (da) begin
      push(pa, req_a);
      m_prio = req_b;
    end else if (db) begin
      push(pb, req_b);
      m_prio = req_a;
    end
    tick();
    a_in_sync = 1'b0;
    b_in_sync = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(a_in_notify && b_in_notify && !arb_out_notify) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 20), 32'd1);
  endtask

  initial begin
    a_in         = mk(read, 8'h00, 8'h00);
    b_in         = mk(read, 8'h00, 8'h00);
    a_in_sync    = 1'b0;
    b_in_sync    = 1'b0;
    arb_out_sync = 1'b0;
    rst          = 1'b0;
    #1;
    do_reset();

    // Reset / idle state
    repeat (5) tick();
    @(negedge clk);
    chk("rst_a_notify", 32'(a_in_notify), 32'd1);
    chk("rst_b_notify", 32'(b_in_notify), 32'd1);
    chk("rst_out_notify", 32'(arb_out_notify), 32'd0);
    chk("rst_arb_out", 32'(arb_out), 32'(mk(read, 8'h00, 8'h00)));
    chk("rst_src", 32'(arb_out_src), 32'(req_a));
    chk("rst_a_count", 32'(a_count), 32'd0);
    chk("rst_b_count", 32'(b_count), 32'd0);

    // Single A with an always-ready consumer
    tick();
    arb_out_sync = 1'b1;
    send(1'b1, mk(write, 8'd7, 8'd1), 1'b0, mk(read, 8'd0, 8'd0));
    @(negedge clk);
    chk("one_notify", 32'(arb_out_notify), 32'd1);
    chk("one_data", 32'(arb_out), 32'(mk(write, 8'd7, 8'd1)));
    chk("one_src", 32'(arb_out_src), 32'(req_a));
    chk("one_a_closed", 32'(a_in_notify), 32'd0);
    @(negedge clk);
    chk("one_done_notify", 32'(arb_out_notify), 32'd0);
    chk("one_done_a_open", 32'(a_in_notify), 32'd1);
    chk("one_done_b_open", 32'(b_in_notify), 32'd1);
    chk("one_a_count", 32'(a_count), 32'd1);

    // Simultaneous pairs: round-robin order alternates
    do_reset();
    arb_out_sync = 1'b1;
    send(1'b1, mk(read, 8'd1, 8'd0), 1'b1, mk(read, 8'd2, 8'd0));
    @(negedge clk);
    chk("pair1_first_x", 32'(arb_out.x), 32'd1);
    chk("pair1_in_closed", 32'(a_in_notify | b_in_notify), 32'd0);
    wait_idle("pair1_idle");
    chk("pair1_a_count", 32'(a_count), sat(m_a, 65535));
    chk("pair1_b_count", 32'(b_count), sat(m_b, 65535));
    tick();
    send(1'b1, mk(write, 8'd3, 8'd0), 1'b1, mk(write, 8'd4, 8'd0));
    @(negedge clk);
    chk("pair2_first_x", 32'(arb_out.x), 32'd4);
    wait_idle("pair2_idle");
    chk("pair2_a_count", 32'(a_count), 32'd2);
    chk("pair2_b_count", 32'(b_count), 32'd2);

    // Consumer stall; A request while closed must be dropped
    tick();
    arb_out_sync = 1'b0;
    send(1'b0, mk(read, 8'd0, 8'd0), 1'b1, mk(read, 8'h55, 8'h00));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_data", 32'(arb_out), 32'(mk(read, 8'h55, 8'h00)));
      chk("stall_src", 32'(arb_out_src), 32'(req_b));
      chk("stall_notify", 32'(arb_out_notify), 32'd1);
      chk("stall_in_closed", 32'(a_in_notify | b_in_notify), 32'd0);
      tick();
      if (i == 2) begin
        a_in      = mk(write, 8'h99, 8'h99);
        a_in_sync = 1'b1;
      end
      if (i == 5) a_in_sync = 1'b0;
    end
    arb_out_sync = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_done_notify", 32'(arb_out_notify), 32'd0);
    chk("stall_done_a_open", 32'(a_in_notify), 32'd1);
    @(negedge clk);
    chk("stall_no_capture", 32'(arb_out_notify), 32'd0);
    chk("stall_a_count", 32'(a_count), sat(m_a, 65535));
    chk("stall_b_count", 32'(b_count), sat(m_b, 65535));

    // Reset while two items are buffered
    tick();
    arb_out_sync = 1'b0;
    send(1'b1, mk(write, 8'h11, 8'h22), 1'b1, mk(read, 8'h33, 8'h44));
    @(negedge clk);
    chk("two_notify", 32'(arb_out_notify), 32'd1);
    chk("two_first", 32'(arb_out), 32'(mk(write, 8'h11, 8'h22)));
    tick();
    do_reset();
    @(negedge clk);
    chk("mid_rst_a_notify", 32'(a_in_notify), 32'd1);
    chk("mid_rst_b_notify", 32'(b_in_notify), 32'd1);
    chk("mid_rst_out_notify", 32'(arb_out_notify), 32'd0);
    chk("mid_rst_arb_out", 32'(arb_out), 32'(mk(read, 8'h00, 8'h00)));
    chk("mid_rst_src", 32'(arb_out_src), 32'(req_a));
    chk("mid_rst_a_count", 32'(a_count), 32'd0);
    chk("mid_rst_b_count", 32'(b_count), 32'd0);
    chk("mid_rst_s_notify", 32'(s_out_notify), 32'd0);
    @(negedge clk);
    chk("mid_rst_lost", 32'(arb_out_notify), 32'd0);

    // Saturation on the 2-bit twin
    tick();
    arb_out_sync = 1'b1;
    for (int k = 0; k < 5; k++) begin
      send(1'b1, mk(write, 8'(k), 8'h00), 1'b0, mk(read, 8'd0, 8'd0));
      wait_idle("sat_idle");
      chk("sat_small_a", 32'(s_a_count), sat(m_a, 3));
      chk("sat_wide_a", 32'(a_count), sat(m_a, 65535));
      tick();
    end
    chk("sat_small_a_final", 32'(s_a_count), 32'd3);
    chk("sat_small_b", 32'(s_b_count), 32'd0);
    chk("sat_twin_last", 32'(s_arb_out), 32'(mk(write, 8'd4, 8'h00)));
    chk("sat_twin_src", 32'(s_arb_out_src), 32'(req_a));
    chk("sat_twin_open", 32'(s_a_notify & s_b_notify), 32'd1);
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
